rtc_alrm_core: RTL and testbench



---
 rtl/rtc_alrm_core_pkg.sv | 18 +
 rtl/rtc_alrm_core_if.sv | 40 ++++
 rtl/rtc_alrm_chan.sv | 45 ++++
 rtl/rtc_alrm_core.sv | 89 ++++++++
 tb/tb_rtc_alrm_core.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_alrm_core_pkg.sv
// Shared constants and types for the RTC alarm core: ista bit positions and alarm mode.
package rtc_pkg;

  localparam int RTC_ISTA_TICK      = 0;
  localparam int RTC_ISTA_OV        = 1;
  localparam int RTC_ISTA_ALRM_BASE = 2;

  typedef enum logic {
    ALRM_ONESHOT  = 1'b0,
    ALRM_PERIODIC = 1'b1
  } alrm_mode_e;

  // A zero reload period means the channel fires once and disarms.
  function automatic alrm_mode_e alrm_mode_of(input logic prd_is_zero);
    return prd_is_zero ? ALRM_ONESHOT : ALRM_PERIODIC;
  endfunction

endpackage

// File: rtl/rtc_alrm_core_if.sv
// Flat strobe bus between the APB register wrapper (master) and the counting core (slave).
// Strobes carry no handshake: every asserted strobe is consumed at the next clock edge.
interface rtc_alrm_core_if #(
  parameter int CNT_WIDTH  = 32,
  parameter int PSCR_WIDTH = 20,
  parameter int NUM_ALRM   = 4
);
  localparam int SEL_WIDTH  = (NUM_ALRM > 1) ? $clog2(NUM_ALRM) : 1;
  localparam int ISTA_WIDTH = NUM_ALRM + 2;

  logic                  en_i;
  logic [PSCR_WIDTH-1:0] pscr_i;
  logic                  cnt_wr_i;
  logic [CNT_WIDTH-1:0]  cnt_wdata_i;
  logic                  alrm_wr_i;
  logic [SEL_WIDTH-1:0]  alrm_sel_i;
  logic [CNT_WIDTH-1:0]  alrm_cmp_i;
  logic [CNT_WIDTH-1:0]  alrm_prd_i;
  logic                  alrm_arm_i;
  logic [ISTA_WIDTH-1:0] ie_i;
  logic [ISTA_WIDTH-1:0] clr_i;
  logic [CNT_WIDTH-1:0]  cnt_o;
  logic                  tick_o;
  logic [NUM_ALRM-1:0]   armed_o;
  logic [ISTA_WIDTH-1:0] ista_o;
  logic                  irq_o;

  modport master (
    output en_i, pscr_i, cnt_wr_i, cnt_wdata_i, alrm_wr_i, alrm_sel_i,
           alrm_cmp_i, alrm_prd_i, alrm_arm_i, ie_i, clr_i,
    input  cnt_o, tick_o, armed_o, ista_o, irq_o
  );

  modport slave (
    input  en_i, pscr_i, cnt_wr_i, cnt_wdata_i, alrm_wr_i, alrm_sel_i,
           alrm_cmp_i, alrm_prd_i, alrm_arm_i, ie_i, clr_i,
    output cnt_o, tick_o, armed_o, ista_o, irq_o
  );

endinterface

// File: rtl/rtc_alrm_chan.sv
// One alarm channel: compare value, reload period and armed state, with match detection.
module rtc_alrm_chan
  import rtc_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] cnt_nxt,
  input  logic                 wr,
  input  logic [CNT_WIDTH-1:0] cmp_in,
  input  logic [CNT_WIDTH-1:0] prd_in,
  input  logic                 arm_in,
  output logic                 match,
  output logic                 armed
);

  logic [CNT_WIDTH-1:0] cmp;
  logic [CNT_WIDTH-1:0] prd;
  logic                 armed_q;
  alrm_mode_e           mode;

  assign mode  = alrm_mode_of(prd == '0);
  // A counter load or a reprogram of this channel in the same cycle suppresses the match.
  assign match = armed_q && tick && !load && !wr && (cnt_nxt == cmp);
  assign armed = armed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp     <= '0;
      prd     <= '0;
      armed_q <= 1'b0;
    end else if (wr) begin
      cmp     <= cmp_in;
      prd     <= prd_in;
      armed_q <= arm_in;
    end else if (match) begin
      if (mode == ALRM_PERIODIC) cmp <= cmp + prd;
      else                       armed_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rtc_alrm_core.sv
// Real-time counter core: prescaler, free-running counter, NUM_ALRM alarm channels and sticky flags.
module rtc_alrm_core
  import rtc_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int PSCR_WIDTH = 20,
  parameter int NUM_ALRM   = 4,
  parameter int SEL_WIDTH  = (NUM_ALRM > 1) ? $clog2(NUM_ALRM) : 1,
  parameter int ISTA_WIDTH = NUM_ALRM + 2
) (
  input logic             clk_i,
  input logic             rst_i,
  rtc_alrm_core_if.slave  bus
);

  logic [PSCR_WIDTH-1:0] psc;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic                  tick;
  logic                  load;
  logic                  ovf;
  logic [NUM_ALRM-1:0]   match;
  logic [NUM_ALRM-1:0]   armed;
  logic [NUM_ALRM-1:0]   wr_sel;
  logic [ISTA_WIDTH-1:0] ista;
  logic [ISTA_WIDTH-1:0] ista_set;

  // The >= compare lets a lowered divisor take effect at once without wrapping psc.
  assign tick    = bus.en_i && (psc >= bus.pscr_i);
  assign load    = bus.cnt_wr_i;
  assign cnt_nxt = cnt + CNT_WIDTH'(1);
  assign ovf     = tick && !load && (cnt == '1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      psc <= '0;
      cnt <= '0;
    end else if (load) begin
      psc <= '0;
      cnt <= bus.cnt_wdata_i;
    end else if (tick) begin
      psc <= '0;
      cnt <= cnt_nxt;
    end else if (bus.en_i) begin
      psc <= psc + PSCR_WIDTH'(1);
    end
  end

  for (genvar k = 0; k < NUM_ALRM; k++) begin : g_chan
    // Selects beyond NUM_ALRM-1 match no channel and are dropped.
    assign wr_sel[k] = bus.alrm_wr_i && (bus.alrm_sel_i == SEL_WIDTH'(k));

    rtc_alrm_chan #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_chan (
      .clk     (clk_i),
      .rst     (rst_i),
      .tick    (tick),
      .load    (load),
      .cnt_nxt (cnt_nxt),
      .wr      (wr_sel[k]),
      .cmp_in  (bus.alrm_cmp_i),
      .prd_in  (bus.alrm_prd_i),
      .arm_in  (bus.alrm_arm_i),
      .match   (match[k]),
      .armed   (armed[k])
    );
  end

  always_comb begin
    ista_set = '0;
    ista_set[RTC_ISTA_TICK] = tick;
    ista_set[RTC_ISTA_OV]   = ovf;
    ista_set[RTC_ISTA_ALRM_BASE +: NUM_ALRM] = match;
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ista <= '0;
    else       ista <= (ista & ~bus.clr_i) | ista_set;
  end

  assign bus.cnt_o   = cnt;
  assign bus.tick_o  = tick;
  assign bus.armed_o = armed;
  assign bus.ista_o  = ista;
  assign bus.irq_o   = |(ista & bus.ie_i);

endmodule

// File: tb/tb_rtc_alrm_core.sv
// Directed bench for rtc_alrm_core: prescaler, counter/overflow, alarms, flags, irq and reset.
module tb_rtc_alrm_core;

  localparam int CW = 32;
  localparam int PW = 20;
  localparam int NA = 4;
  localparam int IW = NA + 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rtc_alrm_core_if #(.CNT_WIDTH(CW), .PSCR_WIDTH(PW), .NUM_ALRM(NA)) bus ();

  rtc_alrm_core #(.CNT_WIDTH(CW), .PSCR_WIDTH(PW), .NUM_ALRM(NA)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en_i        = 1'b0;
    bus.pscr_i      = '0;
    bus.cnt_wr_i    = 1'b0;
    bus.cnt_wdata_i = '0;
    bus.alrm_wr_i   = 1'b0;
    bus.alrm_sel_i  = '0;
    bus.alrm_cmp_i  = '0;
    bus.alrm_prd_i  = '0;
    bus.alrm_arm_i  = 1'b0;
    bus.ie_i        = '0;
    bus.clr_i       = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic alrm_prog(input int sel, input logic [CW-1:0] cmp,
                           input logic [CW-1:0] prd, input logic arm);
    bus.alrm_wr_i  = 1'b1;
    bus.alrm_sel_i = sel[1:0];
    bus.alrm_cmp_i = cmp;
    bus.alrm_prd_i = prd;
    bus.alrm_arm_i = arm;
    cyc();
    bus.alrm_wr_i  = 1'b0;
  endtask

  task automatic load_cnt(input logic [CW-1:0] val);
    bus.cnt_wr_i    = 1'b1;
    bus.cnt_wdata_i = val;
    cyc();
    bus.cnt_wr_i    = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.ie_i = '1;
    #1;
    checks++; if (bus.cnt_o !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0h exp=0", bus.cnt_o); end
    checks++; if (bus.tick_o !== 1'b0) begin failures++; $display("FAIL rst_tick got=%0b exp=0", bus.tick_o); end
    checks++; if (bus.armed_o !== 4'h0) begin failures++; $display("FAIL rst_armed got=%0h exp=0", bus.armed_o); end
    checks++; if (bus.ista_o !== 6'h00) begin failures++; $display("FAIL rst_ista got=%0h exp=0", bus.ista_o); end
    checks++; if (bus.irq_o !== 1'b0) begin failures++; $display("FAIL rst_irq got=%0b exp=0", bus.irq_o); end
    do_reset();
  endtask

  task automatic test_tick_period();
    logic [7:0] pat;
    do_reset();
    bus.pscr_i = 20'd3;
    bus.en_i   = 1'b1;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      pat[i] = bus.tick_o;
      cyc();
    end
    checks++; if (pat !== 8'b1000_1000) begin failures++; $display("FAIL tick_pattern got=%0b exp=10001000", pat); end
    checks++; if (bus.cnt_o !== 32'd2) begin failures++; $display("FAIL tick_cnt got=%0h exp=2", bus.cnt_o); end
    cyc();
    cyc();
    checks++; if (bus.tick_o !== 1'b0) begin failures++; $display("FAIL tick_psc2 got=%0b exp=0", bus.tick_o); end
    bus.pscr_i = 20'd0;
    #1;
    checks++; if (bus.tick_o !== 1'b1) begin failures++; $display("FAIL tick_lower got=%0b exp=1", bus.tick_o); end
    cyc();
    checks++; if (bus.cnt_o !== 32'd3) begin failures++; $display("FAIL tick_lower_cnt got=%0h exp=3", bus.cnt_o); end
    // hold and resume: psc=0 now, run to psc=2, freeze, resume
    bus.pscr_i = 20'd3;
    cyc();
    cyc();
    bus.en_i = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    checks++; if (bus.cnt_o !== 32'd3) begin failures++; $display("FAIL hold_cnt got=%0h exp=3", bus.cnt_o); end
    bus.en_i = 1'b1;
    cyc();
    checks++; if (bus.tick_o !== 1'b1) begin failures++; $display("FAIL resume_tick got=%0b exp=1", bus.tick_o); end
    bus.en_i = 1'b0;
    #1;
    checks++; if (bus.tick_o !== 1'b0) begin failures++; $display("FAIL en_low_tick got=%0b exp=0", bus.tick_o); end
  endtask

  task automatic test_overflow_load();
    do_reset();
    load_cnt(32'hFFFF_FFFE);
    checks++; if (bus.cnt_o !== 32'hFFFF_FFFE) begin failures++; $display("FAIL load_cnt got=%0h exp=fffffffe", bus.cnt_o); end
    bus.en_i = 1'b1;
    cyc();
    checks++; if (bus.ista_o[1] !== 1'b0) begin failures++; $display("FAIL ovf_early got=%0b exp=0", bus.ista_o[1]); end
    cyc();
    bus.en_i = 1'b0;
    checks++; if (bus.cnt_o !== 32'd0) begin failures++; $display("FAIL ovf_cnt got=%0h exp=0", bus.cnt_o); end
    checks++; if (bus.ista_o[1] !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", bus.ista_o[1]); end
    bus.clr_i = 6'b000010;
    cyc();
    bus.clr_i = '0;
    checks++; if (bus.ista_o[1:0] !== 2'b01) begin failures++; $display("FAIL ovf_clr got=%0b exp=01", bus.ista_o[1:0]); end
    // load coincident with a tick
    bus.pscr_i = 20'd3;
    bus.en_i   = 1'b1;
    cyc();
    cyc();
    cyc();
    bus.cnt_wr_i    = 1'b1;
    bus.cnt_wdata_i = 32'd100;
    #1;
    checks++; if (bus.tick_o !== 1'b1) begin failures++; $display("FAIL load_tick_pulse got=%0b exp=1", bus.tick_o); end
    cyc();
    bus.cnt_wr_i = 1'b0;
    checks++; if (bus.cnt_o !== 32'd100) begin failures++; $display("FAIL load_tick_cnt got=%0h exp=64", bus.cnt_o); end
    checks++; if (bus.tick_o !== 1'b0) begin failures++; $display("FAIL load_psc_clr got=%0b exp=0", bus.tick_o); end
    cyc();
    cyc();
    cyc();
    checks++; if (bus.tick_o !== 1'b1) begin failures++; $display("FAIL load_psc_resume got=%0b exp=1", bus.tick_o); end
    bus.en_i = 1'b0;
  endtask

  task automatic test_oneshot();
    do_reset();
    alrm_prog(0, 32'd5, 32'd0, 1'b1);
    checks++; if (bus.armed_o !== 4'b0001) begin failures++; $display("FAIL os_armed got=%0b exp=0001", bus.armed_o); end
    bus.en_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    checks++; if (bus.ista_o[2] !== 1'b0) begin failures++; $display("FAIL os_early got=%0b exp=0", bus.ista_o[2]); end
    cyc();
    bus.en_i = 1'b0;
    checks++; if (bus.cnt_o !== 32'd5) begin failures++; $display("FAIL os_cnt got=%0h exp=5", bus.cnt_o); end
    checks++; if (bus.ista_o[2] !== 1'b1) begin failures++; $display("FAIL os_flag got=%0b exp=1", bus.ista_o[2]); end
    checks++; if (bus.armed_o[0] !== 1'b0) begin failures++; $display("FAIL os_disarm got=%0b exp=0", bus.armed_o[0]); end
    bus.clr_i = 6'b000100;
    cyc();
    bus.clr_i = '0;
    checks++; if (bus.ista_o[2] !== 1'b0) begin failures++; $display("FAIL os_clr got=%0b exp=0", bus.ista_o[2]); end
    // a load onto the compare value while a matching tick is pending must not fire
    alrm_prog(0, 32'd6, 32'd0, 1'b1);
    bus.en_i = 1'b1;
    load_cnt(32'd6);
    bus.en_i = 1'b0;
    checks++; if (bus.cnt_o !== 32'd6) begin failures++; $display("FAIL os_load_cnt got=%0h exp=6", bus.cnt_o); end
    checks++; if (bus.ista_o[2] !== 1'b0) begin failures++; $display("FAIL os_load_nomatch got=%0b exp=0", bus.ista_o[2]); end
    checks++; if (bus.armed_o[0] !== 1'b1) begin failures++; $display("FAIL os_load_armed got=%0b exp=1", bus.armed_o[0]); end
  endtask

  task automatic test_periodic();
    logic [31:0] hits;
    int          n;
    logic [CW-1:0] last;
    do_reset();
    alrm_prog(3, 32'd10, 32'd7, 1'b1);
    load_cnt(32'd9);
    bus.clr_i = '1;
    bus.en_i  = 1'b1;
    hits = '0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (bus.ista_o[5]) hits[bus.cnt_o[4:0]] = 1'b1;
    end
    bus.en_i = 1'b0;
    checks++; if (hits !== 32'h0102_0400) begin failures++; $display("FAIL per_hits got=%0h exp=1020400", hits); end
    checks++; if (bus.armed_o[3] !== 1'b1) begin failures++; $display("FAIL per_armed got=%0b exp=1", bus.armed_o[3]); end
    // wrap of the reloaded compare
    alrm_prog(3, 32'hFFFF_FFFC, 32'd8, 1'b1);
    load_cnt(32'hFFFF_FFFB);
    bus.en_i = 1'b1;
    n = 0;
    last = '0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (bus.ista_o[5]) begin
        n++;
        last = bus.cnt_o;
      end
    end
    bus.en_i  = 1'b0;
    bus.clr_i = '0;
    checks++; if (n !== 2) begin failures++; $display("FAIL wrap_nmatch got=%0d exp=2", n); end
    checks++; if (last !== 32'd4) begin failures++; $display("FAIL wrap_last got=%0h exp=4", last); end
  endtask

  task automatic test_flags_irq();
    do_reset();
    alrm_prog(0, 32'd2, 32'd0, 1'b1);
    alrm_prog(1, 32'd5, 32'd3, 1'b1);
    bus.en_i = 1'b1;
    cyc();
    bus.clr_i = 6'b000100;
    cyc();
    bus.clr_i = '0;
    checks++; if (bus.ista_o[2] !== 1'b1) begin failures++; $display("FAIL set_wins got=%0b exp=1", bus.ista_o[2]); end
    cyc();
    cyc();
    // reprogram channel 1 in the cycle it would match
    bus.alrm_wr_i  = 1'b1;
    bus.alrm_sel_i = 2'd1;
    bus.alrm_cmp_i = 32'd9;
    bus.alrm_prd_i = 32'd0;
    bus.alrm_arm_i = 1'b1;
    cyc();
    bus.alrm_wr_i  = 1'b0;
    checks++; if (bus.cnt_o !== 32'd5) begin failures++; $display("FAIL wr_wins_cnt got=%0h exp=5", bus.cnt_o); end
    checks++; if (bus.ista_o[3] !== 1'b0) begin failures++; $display("FAIL wr_wins_flag got=%0b exp=0", bus.ista_o[3]); end
    checks++; if (bus.armed_o[1] !== 1'b1) begin failures++; $display("FAIL wr_wins_armed got=%0b exp=1", bus.armed_o[1]); end
    for (int i = 0; i < 4; i++) cyc();
    bus.en_i = 1'b0;
    checks++; if (bus.ista_o[3] !== 1'b1) begin failures++; $display("FAIL reprog_flag got=%0b exp=1", bus.ista_o[3]); end
    checks++; if (bus.armed_o[1] !== 1'b0) begin failures++; $display("FAIL reprog_disarm got=%0b exp=0", bus.armed_o[1]); end
    bus.ie_i = '0;
    #1;
    checks++; if (bus.irq_o !== 1'b0 || bus.ista_o === 6'h00) begin failures++; $display("FAIL irq_masked got=%0b exp=0 ista=%0h", bus.irq_o, bus.ista_o); end
    bus.ie_i = 6'b000100;
    #1;
    checks++; if (bus.irq_o !== 1'b1) begin failures++; $display("FAIL irq_ie2 got=%0b exp=1", bus.irq_o); end
    bus.ie_i = 6'b000010;
    #1;
    checks++; if (bus.irq_o !== 1'b0) begin failures++; $display("FAIL irq_ie1 got=%0b exp=0", bus.irq_o); end
    bus.ie_i = '0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    alrm_prog(0, 32'd50, 32'd0, 1'b1);
    alrm_prog(2, 32'd60, 32'd5, 1'b1);
    bus.pscr_i = 20'd3;
    bus.ie_i   = '1;
    bus.en_i   = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    checks++; if (bus.cnt_o !== 32'd1) begin failures++; $display("FAIL pre_rst_cnt got=%0h exp=1", bus.cnt_o); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.cnt_o !== 32'd0) begin failures++; $display("FAIL arst_cnt got=%0h exp=0", bus.cnt_o); end
    checks++; if (bus.armed_o !== 4'h0) begin failures++; $display("FAIL arst_armed got=%0h exp=0", bus.armed_o); end
    checks++; if (bus.ista_o !== 6'h00) begin failures++; $display("FAIL arst_ista got=%0h exp=0", bus.ista_o); end
    checks++; if (bus.irq_o !== 1'b0) begin failures++; $display("FAIL arst_irq got=%0b exp=0", bus.irq_o); end
    checks++; if (bus.tick_o !== 1'b0) begin failures++; $display("FAIL arst_tick got=%0b exp=0", bus.tick_o); end
    cyc();
    rst = 1'b0;
    n = 1;
    while (!bus.tick_o && n < 20) begin
      cyc();
      n++;
    end
    checks++; if (n !== 4) begin failures++; $display("FAIL first_tick_cycles got=%0d exp=4", n); end
    cyc();
    bus.en_i = 1'b0;
    checks++; if (bus.cnt_o !== 32'd1) begin failures++; $display("FAIL post_rst_cnt got=%0h exp=1", bus.cnt_o); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_tick_period();
    test_overflow_load();
    test_oneshot();
    test_periodic();
    test_flags_irq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
